reg_bus_arbiter: RTL

- Shares the single on-chip register bus (op, 11-bit address, 8-bit data, single-cycle xfc strobe) between two masters: port A (I2C sequencer) and port B (on-chip config engine).
- Each master issues a single-cycle xfc pulse. The arbiter latches the request into a one-deep slot per port, grants the bus round-robin, and issues exactly one bus transfer per request.
- For reads, the arbiter returns the read data to the requester.

---
 rtl/reg_bus_arbiter_if.sv | 69 ++++++
 rtl/reg_bus_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter_if.sv
// Requester ports A/B plus the shared register bus, bundled for reg_bus_arbiter.
// Defining REG_ARB_OVF_EN adds the per-port overflow flags and their common clear.
interface reg_bus_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);

    // Port A: I2C sequencer
    logic              a_op;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_xfc;
    logic              a_busy;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rvalid;

    // Port B: config engine
    logic              b_op;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_xfc;
    logic              b_busy;
    logic [DATA_W-1:0] b_rdata;
    logic              b_rvalid;

    // Shared register bus
    logic              bus_op;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_xfc;
    logic [DATA_W-1:0] bus_rdata;

`ifdef REG_ARB_OVF_EN
    logic              a_ovf;
    logic              b_ovf;
    logic              ovf_clr;
`endif

    // Arbiter side
    modport slave (
        input  a_op, a_addr, a_wdata, a_xfc,
        output a_busy, a_rdata, a_rvalid,
        input  b_op, b_addr, b_wdata, b_xfc,
        output b_busy, b_rdata, b_rvalid,
        output bus_op, bus_addr, bus_wdata, bus_xfc,
        input  bus_rdata
`ifdef REG_ARB_OVF_EN
        ,
        output a_ovf, b_ovf,
        input  ovf_clr
`endif
    );

    // Requester / bus-device side
    modport master (
        output a_op, a_addr, a_wdata, a_xfc,
        input  a_busy, a_rdata, a_rvalid,
        output b_op, b_addr, b_wdata, b_xfc,
        input  b_busy, b_rdata, b_rvalid,
        input  bus_op, bus_addr, bus_wdata, bus_xfc,
        output bus_rdata
`ifdef REG_ARB_OVF_EN
        ,
        input  a_ovf, b_ovf,
        output ovf_clr
`endif
    );

endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register bus between two single-request masters.
// Define REG_ARB_OVF_EN to add sticky per-port overflow flags for dropped requests.
module reg_bus_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    reg_bus_arbiter_if.slave bus_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RDWAIT
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } slot_t;

    localparam logic [3:0] LP_RD_LAT = 4'(RD_LAT);

    state_e            r_state;
    state_e            w_state_nxt;
    port_e             r_grant;
    port_e             w_grant_nxt;
    port_e             r_last_grant;
    port_e             w_last_grant_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    slot_t             r_slot_a;
    slot_t             r_slot_b;
    slot_t             w_sel_slot;
    logic              r_busy_a;
    logic              r_busy_b;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic              r_rvalid_a;
    logic              r_rvalid_b;

    logic              w_take_a;
    logic              w_take_b;
    logic              w_wr_done;
    logic              w_rd_done;
    logic              w_clr_a;
    logic              w_clr_b;
    logic              w_rd_a;
    logic              w_rd_b;

    // A request is only accepted into an empty slot; otherwise it is dropped.
    assign w_take_a = bus_if.a_xfc & ~r_busy_a;
    assign w_take_b = bus_if.b_xfc & ~r_busy_b;

    assign w_sel_slot = (r_grant == PORT_A) ? r_slot_a : r_slot_b;

    assign w_clr_a = (w_wr_done | w_rd_done) & (r_grant == PORT_A);
    assign w_clr_b = (w_wr_done | w_rd_done) & (r_grant == PORT_B);
    assign w_rd_a  = w_rd_done & (r_grant == PORT_A);
    assign w_rd_b  = w_rd_done & (r_grant == PORT_B);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_grant      <= PORT_A;
            r_last_grant <= PORT_B;
            r_cnt        <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no branch leaves a signal unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_cnt_nxt        = r_cnt;
        w_wr_done        = 1'b0;
        w_rd_done        = 1'b0;
        bus_if.bus_xfc   = 1'b0;
        bus_if.bus_op    = 1'b0;
        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;

        case (r_state)
            S_IDLE: begin
                if (r_busy_a || r_busy_b) begin
                    if (r_busy_a && r_busy_b) begin
                        w_grant_nxt = (r_last_grant == PORT_A) ? PORT_B : PORT_A;
                    end else if (r_busy_a) begin
                        w_grant_nxt = PORT_A;
                    end else begin
                        w_grant_nxt = PORT_B;
                    end
                    w_last_grant_nxt = w_grant_nxt;
                    w_state_nxt      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                bus_if.bus_xfc   = 1'b1;
                bus_if.bus_op    = w_sel_slot.op;
                bus_if.bus_addr  = w_sel_slot.addr;
                bus_if.bus_wdata = w_sel_slot.op ? w_sel_slot.wdata : '0;
                if (w_sel_slot.op) begin
                    w_wr_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = LP_RD_LAT;
                    w_state_nxt = S_RDWAIT;
                end
            end

            S_RDWAIT: begin
                // Count reaches 1 in the cycle the bus read data is valid.
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy_a <= 1'b0;
            r_slot_a <= '0;
        end else if (w_take_a) begin
            r_busy_a <= 1'b1;
            r_slot_a <= {bus_if.a_op, bus_if.a_addr, bus_if.a_wdata};
        end else if (w_clr_a) begin
            r_busy_a <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy_b <= 1'b0;
            r_slot_b <= '0;
        end else if (w_take_b) begin
            r_busy_b <= 1'b1;
            r_slot_b <= {bus_if.b_op, bus_if.b_addr, bus_if.b_wdata};
        end else if (w_clr_b) begin
            r_busy_b <= 1'b0;
        end
    end

    // Read data is held until the next read completes on the same port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_a <= w_rd_a;
            r_rvalid_b <= w_rd_b;
            if (w_rd_a) begin
                r_rdata_a <= bus_if.bus_rdata;
            end
            if (w_rd_b) begin
                r_rdata_b <= bus_if.bus_rdata;
            end
        end
    end

    assign bus_if.a_busy   = r_busy_a;
    assign bus_if.a_rdata  = r_rdata_a;
    assign bus_if.a_rvalid = r_rvalid_a;
    assign bus_if.b_busy   = r_busy_b;
    assign bus_if.b_rdata  = r_rdata_b;
    assign bus_if.b_rvalid = r_rvalid_b;

`ifdef REG_ARB_OVF_EN
    logic r_ovf_a;
    logic r_ovf_b;

    // A drop and a clear in the same cycle leave the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf_a <= 1'b0;
            r_ovf_b <= 1'b0;
        end else begin
            r_ovf_a <= (bus_if.a_xfc & r_busy_a) | (r_ovf_a & ~bus_if.ovf_clr);
            r_ovf_b <= (bus_if.b_xfc & r_busy_b) | (r_ovf_b & ~bus_if.ovf_clr);
        end
    end

    assign bus_if.a_ovf = r_ovf_a;
    assign bus_if.b_ovf = r_ovf_b;
`endif

endmodule
